// File: rtl/e_mdu_pkg.sv
// MDU opcode encoding shared by the E-stage multiply/divide unit and its users.
// Codes outside this table are treated as NONE by the unit.
package mdu_defs;

    localparam int MDUOP_W = 4;

    localparam logic [MDUOP_W-1:0] NONE  = 4'd0;
    localparam logic [MDUOP_W-1:0] MULT  = 4'd1;
    localparam logic [MDUOP_W-1:0] MULTU = 4'd2;
    localparam logic [MDUOP_W-1:0] DIV   = 4'd3;
    localparam logic [MDUOP_W-1:0] DIVU  = 4'd4;
    localparam logic [MDUOP_W-1:0] MFHI  = 4'd5;
    localparam logic [MDUOP_W-1:0] MFLO  = 4'd6;
    localparam logic [MDUOP_W-1:0] MTHI  = 4'd7;
    localparam logic [MDUOP_W-1:0] MTLO  = 4'd8;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; serves mult/div and mfhi/mflo/mthi/mtlo.
// Latency: result visible MULT_CYCLES+1 / DIV_CYCLES+1 cycles after issue; mf* reads are combinational.
// Backpressure: busy (start | cnt!=0) stalls D-stage; mult/div/mt* arriving while busy are dropped.
module e_mdu
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MDUOP_W-1:0] MDUop,
    input  logic [31:0]        NUM1,
    input  logic [31:0]        NUM2,
    output logic               busy,
    output logic [31:0]        MDUout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi, lo, pend_hi, pend_lo;
    logic             is_mul, is_div, start;
    logic [31:0]      res_hi, res_lo;

    logic [63:0] prod_s, prod_u;
    logic        div_zero, div_ovf;
    logic [31:0] divisor_s, divisor_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    assign prod_s = $signed({{32{NUM1[31]}}, NUM1}) * $signed({{32{NUM2[31]}}, NUM2});
    assign prod_u = {32'd0, NUM1} * {32'd0, NUM2};

    // Divisors are forced to 1 on the trapping cases so the behavioural divide never
    // sees x/0 or INT_MIN/-1; dividing by 1 also yields the required overflow result.
    assign div_zero  = (NUM2 == 32'd0);
    assign div_ovf   = (NUM1 == 32'h8000_0000) && (NUM2 == 32'hFFFF_FFFF);
    assign divisor_s = (div_zero || div_ovf) ? 32'd1 : NUM2;
    assign divisor_u = div_zero ? 32'd1 : NUM2;
    assign quot_s    = $signed(NUM1) / $signed(divisor_s);
    assign rem_s     = $signed(NUM1) % $signed(divisor_s);
    assign quot_u    = NUM1 / divisor_u;
    assign rem_u     = NUM1 % divisor_u;

    always_comb begin
        is_mul = (MDUop == MULT) || (MDUop == MULTU);
        is_div = (MDUop == DIV)  || (MDUop == DIVU);
        start  = (is_mul || is_div) && (cnt == '0);
        res_hi = hi;
        res_lo = lo;
        case (MDUop)
            MULT:  {res_hi, res_lo} = prod_s;
            MULTU: {res_hi, res_lo} = prod_u;
            DIV: begin
                if (!div_zero) begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            DIVU: begin
                if (!div_zero) begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (cnt != '0) begin
            if (cnt == CNT_W'(1)) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            cnt <= cnt - CNT_W'(1);
        end else if (MDUop == MTHI) begin
            hi <= NUM1;
        end else if (MDUop == MTLO) begin
            lo <= NUM1;
        end
    end

    assign busy = start || (cnt != '0);

    always_comb begin
        case (MDUop)
            MFHI:    MDUout = hi;
            MFLO:    MDUout = lo;
            default: MDUout = 32'd0;
        endcase
    end

endmodule
